// File: rtl/period_meter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : period_meter                                                  |
// | Purpose  : Measures period and high time of a slow asynchronous square   |
// |            wave in CLK cycles; one VALID pulse per completed period.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module period_meter #(
    parameter int          CNT_W       = 27,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned MAX_COUNT   = 2**CNT_W - 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SIG_IN,
    output logic [CNT_W-1:0] PERIOD,
    output logic [CNT_W-1:0] HIGH_TIME,
    output logic             VALID,
    output logic             TIMEOUT
);

    localparam logic [CNT_W-1:0] c_max_count = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_sig;
    logic                   w_rise;
    logic                   w_fall;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [CNT_W-1:0]       r_hi_cap;
    logic [CNT_W-1:0]       w_hi_cap_nxt;
    logic [CNT_W-1:0]       r_period;
    logic [CNT_W-1:0]       w_period_nxt;
    logic [CNT_W-1:0]       r_high;
    logic [CNT_W-1:0]       w_high_nxt;
    logic                   r_valid;
    logic                   w_valid_nxt;
    logic                   r_timeout;
    logic                   w_timeout_nxt;

    // Metastability filter; only the last stage and its one-cycle history are used.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], SIG_IN};
            r_prev <= w_sig;
        end
    end

    assign w_sig  = r_sync[SYNC_STAGES-1];
    assign w_rise = w_sig & ~r_prev;
    assign w_fall = ~w_sig & r_prev;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_hi_cap  <= '0;
            r_period  <= '0;
            r_high    <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hi_cap  <= w_hi_cap_nxt;
            r_period  <= w_period_nxt;
            r_high    <= w_high_nxt;
            r_valid   <= w_valid_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hi_cap_nxt  = r_hi_cap;
        w_period_nxt  = r_period;
        w_high_nxt    = r_high;
        w_valid_nxt   = 1'b0;
        w_timeout_nxt = r_timeout;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_rise) begin
                    w_state_nxt  = ST_MEASURE;
                    w_cnt_nxt    = c_one;
                    w_hi_cap_nxt = '0;
                end
            end
            ST_MEASURE: begin
                // A rise landing on the terminal count still closes a valid period.
                if (w_rise) begin
                    w_period_nxt  = r_cnt;
                    w_high_nxt    = r_hi_cap;
                    w_valid_nxt   = 1'b1;
                    w_timeout_nxt = 1'b0;
                    w_cnt_nxt     = c_one;
                end else if (r_cnt == c_max_count) begin
                    w_timeout_nxt = 1'b1;
                    w_period_nxt  = '0;
                    w_high_nxt    = '0;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                    if (w_fall) begin
                        w_hi_cap_nxt = r_cnt;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign PERIOD    = r_period;
    assign HIGH_TIME = r_high;
    assign VALID     = r_valid;
    assign TIMEOUT   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_period_meter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_period_meter                                               |
// | Purpose  : Self-checking bench for period_meter with expected-result     |
// |            queue filled by the stimulus driver.                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_period_meter;

    localparam int c_cnt_w = 27;
    localparam int c_sync  = 2;
    localparam int c_max   = 1000;
    localparam int c_lat   = c_sync + 1;

    logic               CLK    = 1'b0;
    logic               RST    = 1'b1;
    logic               SIG_IN = 1'b0;
    logic [c_cnt_w-1:0] PERIOD;
    logic [c_cnt_w-1:0] HIGH_TIME;
    logic               VALID;
    logic               TIMEOUT;

    int          checks   = 0;
    int          failures = 0;
    int unsigned edge_cnt = 0;
    bit          mon_en   = 1'b0;
    bit          armed    = 1'b0;
    int unsigned prev_per = 0;
    int unsigned prev_hi  = 0;
    int unsigned last_rise = 0;

    typedef struct {
        int unsigned due;
        int unsigned per;
        int unsigned hi;
    } exp_t;
    exp_t sb[$];

    period_meter #(
        .CNT_W      (c_cnt_w),
        .SYNC_STAGES(c_sync),
        .MAX_COUNT  (c_max)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .SIG_IN   (SIG_IN),
        .PERIOD   (PERIOD),
        .HIGH_TIME(HIGH_TIME),
        .VALID    (VALID),
        .TIMEOUT  (TIMEOUT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    // Scoreboard consumer: every VALID must match the oldest queued expectation.
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].due < edge_cnt) begin
                checks++; failures++;
                $display("FAIL missed_valid: no VALID seen, required at edge %0d (now %0d, PERIOD %0d)",
                         sb[0].due, edge_cnt, sb[0].per);
                sb.delete(0);
            end
            if (VALID === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_valid: VALID=1 at edge %0d PERIOD=%0d HIGH_TIME=%0d, required VALID=0",
                             edge_cnt, PERIOD, HIGH_TIME);
                end else begin
                    e = sb[0];
                    sb.delete(0);
                    checks++;
                    if (edge_cnt !== e.due) begin
                        failures++;
                        $display("FAIL valid_timing: VALID at edge %0d, required edge %0d", edge_cnt, e.due);
                    end
                    checks++;
                    if (PERIOD !== c_cnt_w'(e.per)) begin
                        failures++;
                        $display("FAIL period: got %0d, required %0d", PERIOD, e.per);
                    end
                    checks++;
                    if (HIGH_TIME !== c_cnt_w'(e.hi)) begin
                        failures++;
                        $display("FAIL high_time: got %0d, required %0d", HIGH_TIME, e.hi);
                    end
                    checks++;
                    if (TIMEOUT !== 1'b0) begin
                        failures++;
                        $display("FAIL timeout_on_valid: got %0b, required 0", TIMEOUT);
                    end
                end
            end else if (VALID !== 1'b0) begin
                checks++; failures++;
                $display("FAIL valid_x: VALID=%b at edge %0d, required 0 or 1", VALID, edge_cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RST    = 1'b1;
        SIG_IN = 1'b0;
        repeat (2) tick();
        RST   = 1'b0;
        armed = 1'b0;
    endtask

    // Rising edge of SIG_IN; closes the previously driven period if one is open.
    task automatic drive_rise(input int unsigned h, input int unsigned l);
        SIG_IN    = 1'b1;
        last_rise = edge_cnt;
        if (armed) sb.push_back('{last_rise + c_lat, prev_per, prev_hi});
        armed    = 1'b1;
        prev_per = h + l;
        prev_hi  = h;
    endtask

    task automatic drive_period(input int unsigned h, input int unsigned l);
        drive_rise(h, l);
        repeat (h) tick();
        SIG_IN = 1'b0;
        repeat (l) tick();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            SIG_IN = ~SIG_IN;
            tick();
            checks++;
            if ({PERIOD, HIGH_TIME, VALID, TIMEOUT} !== '0) begin
                failures++;
                $display("FAIL reset_outputs: cycle %0d PERIOD=%0d HIGH_TIME=%0d VALID=%b TIMEOUT=%b, required all 0",
                         i, PERIOD, HIGH_TIME, VALID, TIMEOUT);
            end
        end
        SIG_IN = 1'b0;
        RST    = 1'b0;
        armed  = 1'b0;
        mon_en = 1'b1;
        tick();
        checks++;
        if ({PERIOD, HIGH_TIME, VALID, TIMEOUT} !== '0) begin
            failures++;
            $display("FAIL reset_release: PERIOD=%0d HIGH_TIME=%0d VALID=%b TIMEOUT=%b, required all 0",
                     PERIOD, HIGH_TIME, VALID, TIMEOUT);
        end
    endtask

    task automatic test_square();
        apply_reset();
        for (int i = 0; i < 5; i++) drive_period(100, 100);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL square_drain: %0d expected VALIDs outstanding, required 0", sb.size());
        end
        checks++;
        if (PERIOD !== c_cnt_w'(200) || HIGH_TIME !== c_cnt_w'(100)) begin
            failures++;
            $display("FAIL square_hold: PERIOD=%0d HIGH_TIME=%0d, required 200/100", PERIOD, HIGH_TIME);
        end
    endtask

    task automatic test_asym();
        apply_reset();
        for (int i = 0; i < 3; i++) drive_period(3, 4);
        for (int i = 0; i < 4; i++) drive_period(1, 1);
        repeat (5) tick();
        checks++;
        if (PERIOD !== c_cnt_w'(2) || HIGH_TIME !== c_cnt_w'(1)) begin
            failures++;
            $display("FAIL min_period_hold: PERIOD=%0d HIGH_TIME=%0d, required 2/1", PERIOD, HIGH_TIME);
        end
    endtask

    task automatic test_timeout();
        int unsigned want;
        bit          seen;
        apply_reset();
        for (int i = 0; i < 3; i++) drive_period(100, 100);
        want = last_rise + c_lat + c_max;
        seen = 1'b0;
        for (int i = 0; i < 2 * c_max && !seen; i++) begin
            tick();
            if (TIMEOUT === 1'b1) seen = 1'b1;
        end
        armed = 1'b0;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL timeout_missing: TIMEOUT=%b after %0d cycles, required 1", TIMEOUT, 2 * c_max);
        end else if (edge_cnt !== want) begin
            failures++;
            $display("FAIL timeout_timing: TIMEOUT rose at edge %0d, required edge %0d", edge_cnt, want);
        end
        checks++;
        if (PERIOD !== '0 || HIGH_TIME !== '0) begin
            failures++;
            $display("FAIL timeout_clear: PERIOD=%0d HIGH_TIME=%0d, required 0/0", PERIOD, HIGH_TIME);
        end
        drive_period(100, 100);
        checks++;
        if (TIMEOUT !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky: TIMEOUT=%b after first resumed rise, required 1", TIMEOUT);
        end
        drive_period(100, 100);
        checks++;
        if (TIMEOUT !== 1'b0) begin
            failures++;
            $display("FAIL timeout_release: TIMEOUT=%b after VALID, required 0", TIMEOUT);
        end
    endtask

    task automatic test_max_boundary();
        apply_reset();
        drive_period(500, 500);
        drive_period(500, 501);
        checks++;
        if (PERIOD !== c_cnt_w'(c_max) || TIMEOUT !== 1'b0) begin
            failures++;
            $display("FAIL exact_max: PERIOD=%0d TIMEOUT=%b, required %0d/0", PERIOD, TIMEOUT, c_max);
        end
        armed = 1'b0;
        drive_period(5, 5);
        checks++;
        if (TIMEOUT !== 1'b1 || PERIOD !== '0 || HIGH_TIME !== '0) begin
            failures++;
            $display("FAIL over_max: TIMEOUT=%b PERIOD=%0d HIGH_TIME=%0d, required 1/0/0",
                     TIMEOUT, PERIOD, HIGH_TIME);
        end
        drive_period(5, 5);
        repeat (5) tick();
        checks++;
        if (TIMEOUT !== 1'b0 || PERIOD !== c_cnt_w'(10)) begin
            failures++;
            $display("FAIL over_max_recover: TIMEOUT=%b PERIOD=%0d, required 0/10", TIMEOUT, PERIOD);
        end
    endtask

    task automatic test_rst_mid();
        apply_reset();
        drive_period(40, 160);
        drive_period(40, 160);
        drive_rise(40, 160);
        repeat (40) tick();
        SIG_IN = 1'b0;
        repeat (10) tick();
        RST = 1'b1;
        tick();
        RST   = 1'b0;
        armed = 1'b0;
        checks++;
        if ({PERIOD, HIGH_TIME, VALID, TIMEOUT} !== '0) begin
            failures++;
            $display("FAIL mid_reset: PERIOD=%0d HIGH_TIME=%0d VALID=%b TIMEOUT=%b, required all 0",
                     PERIOD, HIGH_TIME, VALID, TIMEOUT);
        end
        repeat (149) tick();
        drive_period(40, 160);
        drive_period(40, 160);
        repeat (5) tick();
    endtask

    initial begin
        test_reset();
        test_square();
        test_asym();
        test_timeout();
        test_max_boundary();
        test_rst_mid();
        repeat (5) tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL final_drain: %0d expected VALIDs outstanding, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
